// File: rtl/counter_pkg.sv
// Shared types and helpers for the programmable modulus counter.
package counter_pkg;

    typedef enum logic [1:0] {
        CNT_IDLE,
        CNT_RUN,
        CNT_DONE
    } cnt_state_e;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

    // Largest limit representable in a w-bit counter (saturates at 32 bits).
    function automatic int unsigned max_limit(input int unsigned w);
        if (w >= 32) begin
            return 32'hFFFF_FFFF;
        end
        return (32'd1 << w) - 32'd1;
    endfunction

endpackage

// File: rtl/mod_counter.sv
// Runtime-programmable modulus counter with up/down direction, load,
// start/stop/one-shot control and a registered terminal-count pulse.
// Optional feature macro: MOD_COUNTER_CAPTURE_EN adds a count capture port.
module mod_counter
    import counter_pkg::*;
#(
    parameter int unsigned W         = 8,
    parameter int unsigned RST_LIMIT = max_limit(W)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         stop,
    input  logic         en,
    input  logic         dir,
    input  logic         oneshot,
    input  logic [W-1:0] limit,
    input  logic         load,
    input  logic [W-1:0] load_val,
`ifdef MOD_COUNTER_CAPTURE_EN
    input  logic         capture,
    output logic [W-1:0] cap_val,
    output logic         cap_valid,
`endif
    output logic [W-1:0] count,
    output logic         tc,
    output logic         busy,
    output logic         done
);

    localparam logic [W-1:0] ONE = W'(1);

    // RST_LIMIT only documents the helper-reported default; reject nonsense values.
    if (RST_LIMIT > max_limit(W)) begin : g_bad_rst_limit
        $error("mod_counter: RST_LIMIT exceeds the W-bit range");
    end

    cnt_state_e   state_q, state_d;
    logic [W-1:0] count_q, count_d;
    logic         tc_q, tc_d;

    logic         terminal;
    logic [W-1:0] load_clamped;
    logic [W-1:0] restart_val;

    // Next state / next count / terminal decision, priority load > stop > start > step.
    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        tc_d         = 1'b0;
        load_clamped = (load_val > limit) ? limit : load_val;
        restart_val  = (dir == DIR_DOWN) ? limit : '0;
        // >= on the up path makes a limit lowered below count terminate instead of overflowing.
        terminal     = (dir == DIR_DOWN) ? (count_q == '0) : (count_q >= limit);

        if (load) begin
            count_d = load_clamped;
        end else if (stop && (state_q == CNT_RUN)) begin
            state_d = CNT_IDLE;
        end else if (start && (state_q != CNT_RUN)) begin
            state_d = CNT_RUN;
            count_d = restart_val;
        end else if ((state_q == CNT_RUN) && en) begin
            if (terminal) begin
                tc_d = 1'b1;
                if (oneshot) begin
                    state_d = CNT_DONE;
                end else begin
                    count_d = restart_val;
                end
            end else if (dir == DIR_DOWN) begin
                count_d = count_q - ONE;
            end else begin
                count_d = count_q + ONE;
            end
        end
    end

    // State, count and terminal-count registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= CNT_IDLE;
            count_q <= '0;
            tc_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            tc_q    <= tc_d;
        end
    end

`ifdef MOD_COUNTER_CAPTURE_EN
    logic [W-1:0] cap_val_q, cap_val_d;
    logic         cap_valid_q, cap_valid_d;
    logic         start_taken;

    // Capture snapshot: an accepted start clears validity, capture on the same edge re-arms it.
    always_comb begin
        cap_val_d   = cap_val_q;
        cap_valid_d = cap_valid_q;
        start_taken = !load && !(stop && (state_q == CNT_RUN))
                      && start && (state_q != CNT_RUN);
        if (start_taken) begin
            cap_valid_d = 1'b0;
        end
        if (capture) begin
            cap_val_d   = count_q;
            cap_valid_d = 1'b1;
        end
    end

    // Capture registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cap_val_q   <= '0;
            cap_valid_q <= 1'b0;
        end else begin
            cap_val_q   <= cap_val_d;
            cap_valid_q <= cap_valid_d;
        end
    end

    assign cap_val   = cap_val_q;
    assign cap_valid = cap_valid_q;
`endif

    assign count = count_q;
    assign tc    = tc_q;
    assign busy  = (state_q == CNT_RUN);
    assign done  = (state_q == CNT_DONE);

endmodule
